memory_access_ctrl: RTL and testbench
=====================================

// Module: memory_access_ctrl
// PURPOSE
//  Request front-end for the one-read/one-write dual-port RAM (64-bit word, 8 byte enables).
//  Accepts byte-addressed read/write requests, builds per-byte write enables and lane-aligned data.
//  Issues RAM reads and returns lane-aligned read responses through a 2-entry output buffer with backpressure.
//  Single clock; the RAM's wr_clk and rd_clk are both tied to clk.
// PARAMETERS
//  AW  14  RAM word-address width; byte address is AW+3 bits
//  TW  32  tag width; read tag returned with response (e.g. source address)
// PORTS
//  clk          in   1      clock, rising edge
//  nreset       in   1      asynchronous active-low reset
//  access_in    in   1      request valid
//  write_in     in   1      1=write, 0=read
//  datamode_in  in   2      0=byte 1=half 2=word 3=double
//  addr_in      in   AW+3   byte address
//  data_in      in   64     write data, right-justified (byte in [7:0])
//  tag_in       in   TW     read tag
//  wait_out     out  1      request not accepted this cycle
//  access_out   out  1      read response valid
//  data_out     out  64     read data, right-justified, zero-extended to 64
//  tag_out      out  TW     tag of response
//  wait_in      in   1      downstream stall; response held while high
//  err_out      out  1      misalignment pulse (constant 0 without MEM_ALIGN_CHECK_EN)
//  mem_wr_en    out  8      RAM byte write enables
//  mem_wr_addr  out  AW     RAM write word address
//  mem_wr_data  out  64     RAM write data, lane-shifted
//  mem_rd_en    out  1      RAM read enable
//  mem_rd_addr  out  AW     RAM read word address
//  mem_rd_data  in   64     RAM read data, valid cycle after mem_rd_en
// BEHAVIOUR
//  - Accept = access_in & !wait_out. One request per cycle max.
//  - Write: mem_wr_* driven combinationally in accept cycle; RAM commits at that edge.
//    mem_wr_en = {01,03,0F,FF}[datamode] << addr[2:0]; mem_wr_data = data_in << 8*addr[2:0].
//  - Read: mem_rd_en/addr driven combinationally in accept cycle N; inflight flag set at edge N.
//    mem_rd_data captured in cycle N+1 as (mem_rd_data >> 8*addr[2:0]) masked to datamode width.
//    Buffer write at edge N+1; access_out high from cycle N+2. Latency 2 cycles.
//  - Read in cycle after a write to same word returns new data (no hazard logic needed).
//  - Output buffer: 2-entry FIFO of {data,tag}, head drives outputs; pops when access_out & !wait_in.
//  - wait_out = (occupancy + inflight) >= 2, from registers only; applies to reads and writes (keeps order).
//  - Full buffer with wait_in held: head and tag stable, no overwrite, no drop.
//  - Simultaneous push and pop at occupancy 1 or 2: occupancy unchanged, order preserved.
//  - Misaligned without macro: low address bits below datamode alignment ignored (forced to 0).
//  - Reset (any time, async): occupancy=0, inflight=0, access_out=0, data_out=0, tag_out=0,
//    err_out=0, wait_out=0; in-flight read discarded. mem_* are combinational from request: 0 while access_in=0.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: misaligned accepted request (half addr[0], word addr[1:0], double addr[2:0]
//    nonzero) performs no RAM access and no response; err_out pulses 1 cycle, registered (cycle after accept).
//  Not defined: err_out tied 0, low bits masked as above.
// STRUCTURE
//  Package mem_ctrl_pkg: DATAMODE_BYTE/HALF/WORD/DOUBLE encodings, be_mask(datamode,addr) function,
//    rd_align(data,datamode,addr) function, MEM_DW=64, MEM_WED=8 constants.
//  Sub-module mem_ctrl_outbuf: 2-entry registered FIFO with push/pop/occupancy, width 64+TW.
// TESTING
//  1 Write double 0x1122334455667788 @0x10; read double @0x10 -> data_out 0x1122334455667788, 2 cycles after accept.
//  2 Write byte 0xAB @0x13 -> mem_wr_en=0x08, mem_wr_data[31:24]=0xAB; read byte @0x13 -> data_out=0xAB.
//  3 Reads to 4 addresses back-to-back, wait_in=1 -> wait_out after 2; release -> 4 responses in order, none lost.
//  4 wait_in toggled every cycle during read stream -> data_out/tag_out stable while stalled, tags in order.
//  5 nreset low while read in flight and buffer holds 1 -> all outputs 0 immediately; no response after release.
//  6 Half write @0x01 with MEM_ALIGN_CHECK_EN -> err_out=1 one cycle, mem_wr_en=0; without macro -> mem_wr_en=0x03.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and lane helpers for the memory access controller.
// Helpers: byte-enable mask, lane alignment and read-data extraction.
package mem_ctrl_pkg;

    localparam int MEM_DW  = 64;
    localparam int MEM_WED = 8;

    typedef enum logic [1:0] {
        DATAMODE_BYTE   = 2'd0,
        DATAMODE_HALF   = 2'd1,
        DATAMODE_WORD   = 2'd2,
        DATAMODE_DOUBLE = 2'd3
    } datamode_e;

    // Lane offset with the bits below the access-size alignment cleared
    function automatic logic [2:0] lane_align(input logic [1:0] datamode, input logic [2:0] addr);
        logic [2:0] lane;
        case (datamode)
            DATAMODE_BYTE: lane = addr;
            DATAMODE_HALF: lane = addr & 3'b110;
            DATAMODE_WORD: lane = addr & 3'b100;
            default:       lane = 3'b000;
        endcase
        return lane;
    endfunction

    function automatic logic misaligned(input logic [1:0] datamode, input logic [2:0] addr);
        return (lane_align(datamode, addr) != addr);
    endfunction

    function automatic logic [MEM_WED-1:0] be_mask(input logic [1:0] datamode, input logic [2:0] addr);
        logic [MEM_WED-1:0] base;
        case (datamode)
            DATAMODE_BYTE: base = 8'h01;
            DATAMODE_HALF: base = 8'h03;
            DATAMODE_WORD: base = 8'h0F;
            default:       base = 8'hFF;
        endcase
        return base << lane_align(datamode, addr);
    endfunction

    function automatic logic [MEM_DW-1:0] rd_align(input logic [MEM_DW-1:0] data,
                                                   input logic [1:0] datamode,
                                                   input logic [2:0] addr);
        logic [MEM_DW-1:0] shifted;
        logic [MEM_DW-1:0] mask;
        shifted = data >> {lane_align(datamode, addr), 3'b000};
        case (datamode)
            DATAMODE_BYTE: mask = 64'h0000_0000_0000_00FF;
            DATAMODE_HALF: mask = 64'h0000_0000_0000_FFFF;
            DATAMODE_WORD: mask = 64'h0000_0000_FFFF_FFFF;
            default:       mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return shifted & mask;
    endfunction

endpackage

// File: rtl/mem_ctrl_outbuf.sv
// Two-entry response FIFO; the head entry is a register that drives the outputs directly.
module mem_ctrl_outbuf #(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occupancy,
    output logic         valid,
    output logic [W-1:0] head
);

    logic [1:0]   count_r;
    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic         pop_s;
    logic         push_s;

    // Pops only from a non-empty buffer; pushes never overwrite a full one
    always_comb begin
        pop_s  = pop & (count_r != 2'd0);
        push_s = push & ((count_r != 2'd2) | pop_s);
    end

    // Head/tail storage and occupancy count
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_r <= 2'd0;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= push_data;
                    end else begin
                        tail_r <= push_data;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_r <= push_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= push_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign occupancy = count_r;
    assign valid     = (count_r != 2'd0);
    assign head      = head_r;

endmodule

// File: rtl/memory_access_ctrl.sv
// Byte-addressed request front-end for a 1R/1W 64-bit RAM with a 2-entry response buffer.
// Optional: MEM_ALIGN_CHECK_EN rejects misaligned requests and pulses err_out instead.
module memory_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AW = 14,
    parameter int TW = 32
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                access_in,
    input  logic                write_in,
    input  logic [1:0]          datamode_in,
    input  logic [AW+2:0]       addr_in,
    input  logic [MEM_DW-1:0]   data_in,
    input  logic [TW-1:0]       tag_in,
    output logic                wait_out,
    output logic                access_out,
    output logic [MEM_DW-1:0]   data_out,
    output logic [TW-1:0]       tag_out,
    input  logic                wait_in,
    output logic                err_out,
    output logic [MEM_WED-1:0]  mem_wr_en,
    output logic [AW-1:0]       mem_wr_addr,
    output logic [MEM_DW-1:0]   mem_wr_data,
    output logic                mem_rd_en,
    output logic [AW-1:0]       mem_rd_addr,
    input  logic [MEM_DW-1:0]   mem_rd_data
);

    logic [1:0]       occ_s;
    logic             inflight_r;
    logic [1:0]       rd_mode_r;
    logic [2:0]       rd_lane_r;
    logic [TW-1:0]    rd_tag_r;
    logic             err_r;
    logic             wait_s;
    logic             accept_s;
    logic             misalign_s;
    logic             wr_do_s;
    logic             rd_do_s;
    logic [2:0]       lane_s;
    logic             pop_s;
    logic [MEM_DW+TW-1:0] push_data_s;
    logic [MEM_DW+TW-1:0] head_s;

    // Throttle counts the in-flight read so a buffer slot is always reserved for it
    always_comb begin
        wait_s   = (({1'b0, occ_s} + {2'b00, inflight_r}) >= 3'd2);
        accept_s = access_in & ~wait_s;
        lane_s   = lane_align(datamode_in, addr_in[2:0]);
`ifdef MEM_ALIGN_CHECK_EN
        misalign_s = misaligned(datamode_in, addr_in[2:0]);
`else
        misalign_s = 1'b0;
`endif
        wr_do_s  = accept_s & ~misalign_s & write_in;
        rd_do_s  = accept_s & ~misalign_s & ~write_in;
    end

    // RAM port drive, held at zero unless a request is performed this cycle
    always_comb begin
        mem_wr_en   = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        if (wr_do_s) begin
            mem_wr_en   = be_mask(datamode_in, addr_in[2:0]);
            mem_wr_addr = addr_in[AW+2:3];
            mem_wr_data = data_in << {lane_s, 3'b000};
        end else if (rd_do_s) begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = addr_in[AW+2:3];
        end else begin
            mem_rd_en   = 1'b0;
        end
    end

    // In-flight read context and registered misalignment pulse
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            inflight_r <= 1'b0;
            rd_mode_r  <= 2'd0;
            rd_lane_r  <= 3'd0;
            rd_tag_r   <= '0;
            err_r      <= 1'b0;
        end else begin
            inflight_r <= rd_do_s;
            err_r      <= accept_s & misalign_s;
            if (rd_do_s) begin
                rd_mode_r <= datamode_in;
                rd_lane_r <= lane_s;
                rd_tag_r  <= tag_in;
            end else begin
                rd_mode_r <= rd_mode_r;
                rd_lane_r <= rd_lane_r;
                rd_tag_r  <= rd_tag_r;
            end
        end
    end

    assign push_data_s = {rd_align(mem_rd_data, rd_mode_r, rd_lane_r), rd_tag_r};
    assign pop_s       = access_out & ~wait_in;

    mem_ctrl_outbuf #(
        .W (MEM_DW + TW)
    ) u_outbuf (
        .clk       (clk),
        .nreset    (nreset),
        .push      (inflight_r),
        .push_data (push_data_s),
        .pop       (pop_s),
        .occupancy (occ_s),
        .valid     (access_out),
        .head      (head_s)
    );

    assign data_out = head_s[TW +: MEM_DW];
    assign tag_out  = head_s[TW-1:0];
    assign wait_out = wait_s;
    assign err_out  = err_r;

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Self-checking bench: byte-array reference model with a response queue, directed plus random steps.
module tb_memory_access_ctrl;

    localparam int AW = 14;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          nreset;
    logic          access_in, write_in, wait_in;
    logic [1:0]    datamode_in;
    logic [AW+2:0] addr_in;
    logic [63:0]   data_in;
    logic [TW-1:0] tag_in;
    logic          wait_out, access_out, err_out;
    logic [63:0]   data_out;
    logic [TW-1:0] tag_out;
    logic [7:0]    mem_wr_en;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [63:0]   mem_wr_data;
    logic          mem_rd_en;
    logic [63:0]   mem_rd_data = 64'd0;

    always #5 clk = ~clk;

    memory_access_ctrl #(.AW(AW), .TW(TW)) dut (
        .clk(clk), .nreset(nreset), .access_in(access_in), .write_in(write_in),
        .datamode_in(datamode_in), .addr_in(addr_in), .data_in(data_in), .tag_in(tag_in),
        .wait_out(wait_out), .access_out(access_out), .data_out(data_out), .tag_out(tag_out),
        .wait_in(wait_in), .err_out(err_out), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data)
    );

    // Behavioural 1R/1W RAM with registered read
    logic [63:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
        for (int b = 0; b < 8; b++)
            if (mem_wr_en[b]) ram[mem_wr_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
    end

    typedef struct packed {
        logic [63:0]   d;
        logic [TW-1:0] t;
    } resp_t;

    logic [7:0] ref_bytes [0:(1<<(AW+3))-1];
    resp_t      exp_q[$];
    bit         infl;
    resp_t      infl_resp;
    bit         err_pend;
    int         n_popped;
    int         n_checks;
    int         n_errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check, then advance the reference model
    task automatic tick(input logic acc, input logic wr, input logic [1:0] dm,
                        input logic [AW+2:0] a, input logic [63:0] d,
                        input logic [TW-1:0] t, input logic wi, output bit accepted);
        int            n;
        logic [AW+2:0] base;
        bit            ew, mis;
        logic [7:0]    be;
        logic [63:0]   rv;
        @(negedge clk);
        access_in = acc; write_in = wr; datamode_in = dm; addr_in = a;
        data_in = d; tag_in = t; wait_in = wi;
        #1;
        n    = 1 << dm;
        base = a;
        base[2:0] = a[2:0] & ~3'(n - 1);
        ew   = (exp_q.size() + int'(infl)) >= 2;
        accepted = acc && !ew;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (base != a);
`else
        mis = 1'b0;
`endif
        chk("wait_out", wait_out, ew);
        chk("access_out", access_out, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("data_out", data_out, exp_q[0].d);
            chk("tag_out", tag_out, exp_q[0].t);
        end
        chk("err_out", err_out, err_pend);
        be = 8'(((1 << n) - 1) << base[2:0]);
        if (accepted && wr && !mis) begin
            chk("mem_wr_en", mem_wr_en, be);
            chk("mem_wr_addr", mem_wr_addr, base[AW+2:3]);
            chk("mem_wr_data", mem_wr_data, d << (8 * base[2:0]));
        end else begin
            chk("mem_wr_en_idle", mem_wr_en, 8'h00);
        end
        if (accepted && !wr && !mis) begin
            chk("mem_rd_en", mem_rd_en, 1'b1);
            chk("mem_rd_addr", mem_rd_addr, base[AW+2:3]);
        end else begin
            chk("mem_rd_en_idle", mem_rd_en, 1'b0);
        end
        if (exp_q.size() != 0 && !wi) begin
            void'(exp_q.pop_front());
            n_popped++;
        end
        if (infl) exp_q.push_back(infl_resp);
        infl = accepted && !wr && !mis;
        if (infl) begin
            rv = 64'd0;
            for (int i = 0; i < n; i++) rv[8*i +: 8] = ref_bytes[int'(base) + i];
            infl_resp = '{d: rv, t: t};
        end
        if (accepted && wr && !mis)
            for (int i = 0; i < n; i++) ref_bytes[int'(base) + i] = d[8*i +: 8];
        err_pend = accepted && mis;
    endtask

    initial begin
        bit            ok;
        int            k, cyc, p0;
        logic [AW+2:0] addrs [4];
        n_checks = 0; n_errors = 0; n_popped = 0;
        infl = 1'b0; err_pend = 1'b0;
        nreset = 1'b0; access_in = 1'b0; write_in = 1'b0; datamode_in = 2'd0;
        addr_in = '0; data_in = 64'd0; tag_in = '0; wait_in = 1'b0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 64'd0;
        for (int i = 0; i < (1 << (AW + 3)); i++) ref_bytes[i] = 8'd0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_access_out", access_out, 1'b0);
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_tag_out", tag_out, 32'd0);
        chk("rst_wait_out", wait_out, 1'b0);
        chk("rst_err_out", err_out, 1'b0);
        @(negedge clk);
        nreset = 1'b1;

        // Double write then read back, response visible two cycles after accept
        tick(1'b1, 1'b1, 2'd3, 17'h10, 64'h1122334455667788, 32'h0, 1'b0, ok);
        tick(1'b1, 1'b0, 2'd3, 17'h10, 64'd0, 32'h10, 1'b0, ok);
        tick(1'b0, 1'b0, 2'd0, 17'h0, 64'd0, 32'h0, 1'b0, ok);
        chk("t1_not_yet", access_out, 1'b0);
        tick(1'b0, 1'b0, 2'd0, 17'h0, 64'd0, 32'h0, 1'b0, ok);
        chk("t1_data", data_out, 64'h1122334455667788);
        chk("t1_tag", tag_out, 32'h10);

        // Byte write into lane 3, then byte read
        tick(1'b1, 1'b1, 2'd0, 17'h13, 64'h00000000000000AB, 32'h0, 1'b0, ok);
        chk("t2_we", mem_wr_en, 8'h08);
        chk("t2_lane", mem_wr_data[31:24], 8'hAB);
        tick(1'b1, 1'b0, 2'd0, 17'h13, 64'd0, 32'h13, 1'b0, ok);
        repeat (2) tick(1'b0, 1'b0, 2'd0, 17'h0, 64'd0, 32'h0, 1'b0, ok);
        chk("t2_data", data_out, 64'h00000000000000AB);

        // Misaligned half write
        tick(1'b1, 1'b1, 2'd1, 17'h01, 64'h0000_0000_0000_5A5A, 32'h0, 1'b0, ok);
`ifdef MEM_ALIGN_CHECK_EN
        chk("t6_we", mem_wr_en, 8'h00);
        tick(1'b0, 1'b0, 2'd0, 17'h0, 64'd0, 32'h0, 1'b0, ok);
        chk("t6_err", err_out, 1'b1);
        tick(1'b0, 1'b0, 2'd0, 17'h0, 64'd0, 32'h0, 1'b0, ok);
        chk("t6_err_clr", err_out, 1'b0);
`else
        chk("t6_we", mem_wr_en, 8'h03);
        tick(1'b0, 1'b0, 2'd0, 17'h0, 64'd0, 32'h0, 1'b0, ok);
        chk("t6_err", err_out, 1'b0);
`endif

        // Four back-to-back reads under stall, then release
        addrs[0] = 17'h10; addrs[1] = 17'h18; addrs[2] = 17'h40; addrs[3] = 17'h08;
        p0 = n_popped; k = 0; cyc = 0;
        while ((k < 4 || exp_q.size() != 0 || infl) && cyc < 40) begin
            tick(k < 4, 1'b0, 2'd3, addrs[k % 4], 64'd0, 32'(100 + k), cyc < 6, ok);
            if (cyc == 4) chk("t3_wait", wait_out, 1'b1);
            if (ok && k < 4) k++;
            cyc++;
        end
        chk("t3_responses", 64'(n_popped - p0), 64'd4);

        // Stream of reads with downstream stall toggling every cycle
        p0 = n_popped; k = 0; cyc = 0;
        while ((k < 8 || exp_q.size() != 0 || infl) && cyc < 80) begin
            tick(k < 8, 1'b0, 2'($urandom_range(0, 3)), 17'($urandom_range(0, 255)),
                 64'd0, 32'(200 + k), cyc[0], ok);
            if (ok && k < 8) k++;
            cyc++;
        end
        chk("t4_responses", 64'(n_popped - p0), 64'd8);

        // Reset with one buffered response and one read in flight
        tick(1'b1, 1'b0, 2'd3, 17'h20, 64'd0, 32'h55, 1'b1, ok);
        tick(1'b1, 1'b0, 2'd3, 17'h28, 64'd0, 32'h66, 1'b1, ok);
        @(negedge clk);
        #1;
        chk("t5_pre_access", access_out, 1'b1);
        nreset = 1'b0; access_in = 1'b0;
        #1;
        chk("t5_access_out", access_out, 1'b0);
        chk("t5_data_out", data_out, 64'd0);
        chk("t5_tag_out", tag_out, 32'd0);
        chk("t5_wait_out", wait_out, 1'b0);
        chk("t5_err_out", err_out, 1'b0);
        exp_q.delete(); infl = 1'b0; err_pend = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        repeat (4) tick(1'b0, 1'b0, 2'd0, 17'h0, 64'd0, 32'h0, 1'b0, ok);

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                 2'($urandom_range(0, 3)), 17'($urandom_range(0, 255)),
                 {$urandom, $urandom}, 32'($urandom), $urandom_range(0, 9) < 3, ok);
        end
        repeat (5) tick(1'b0, 1'b0, 2'd0, 17'h0, 64'd0, 32'h0, 1'b0, ok);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
